// File: rtl/aes_word_packer.sv
// Word-serial bridge to the 128-bit AES core: gathers data/key words, pulses start,
// captures the result on a rising done and streams it back out MSW first.
module aes_word_packer #(
    parameter int WORD_W  = 16,
    parameter int NWORDS  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic                         wr_sel,
    input  logic [$clog2(NWORDS)-1:0]    wr_idx,
    input  logic [WORD_W-1:0]            wr_data,
    input  logic                         go,
    input  logic                         encr_decr_in,
    output logic [WORD_W*NWORDS-1:0]     aes_in,
    output logic [WORD_W*NWORDS-1:0]     aes_key,
    output logic                         aes_ed,
    output logic                         aes_start,
    input  logic                         aes_done,
    input  logic [WORD_W*NWORDS-1:0]     aes_out,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [WORD_W-1:0]            rd_data,
    output logic [$clog2(NWORDS)-1:0]    rd_idx,
    output logic                         busy,
    output logic                         done_pulse,
    output logic                         error
);

    localparam int BLK_W = WORD_W * NWORDS;
    localparam int IDX_W = $clog2(NWORDS);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_UNLOAD} state_t;

    state_t              state_q, state_d;
    logic [BLK_W-1:0]    data_q, data_d;
    logic [BLK_W-1:0]    key_q, key_d;
    logic [BLK_W-1:0]    res_q, res_d;
    logic                ed_q, ed_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
    logic                error_q, error_d;
    logic                done_pulse_q, done_pulse_d;
    logic                done_q;
    logic                done_rise;

    // Word 0 occupies the most significant slice of a block.
    function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0] blk,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [WORD_W-1:0] w);
        logic [BLK_W-1:0] r;
        r = blk;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx == IDX_W'(i)) r[(NWORDS-1-i)*WORD_W +: WORD_W] = w;
        end
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] get_word(input logic [BLK_W-1:0] blk,
                                                   input logic [IDX_W-1:0] idx);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx == IDX_W'(i)) r = blk[(NWORDS-1-i)*WORD_W +: WORD_W];
        end
        return r;
    endfunction

    // A done level left over from an earlier operation must not count as completion.
    assign done_rise = aes_done & ~done_q;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        key_d        = key_q;
        res_d        = res_q;
        ed_d         = ed_q;
        cnt_d        = cnt_q;
        rd_idx_d     = rd_idx_q;
        error_d      = error_q;
        done_pulse_d = 1'b0;
        cnt_inc      = cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (wr_valid) begin
                    if (wr_sel) key_d  = put_word(key_q, wr_idx, wr_data);
                    else        data_d = put_word(data_q, wr_idx, wr_data);
                end
                if (go) begin
                    ed_d    = encr_decr_in;
                    error_d = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    res_d    = aes_out;
                    rd_idx_d = '0;
                    state_d  = S_UNLOAD;
                end else if (cnt_inc == CNT_LAST) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_UNLOAD: begin
                if (rd_ready) begin
                    if (rd_idx_q == IDX_LAST) begin
                        rd_idx_d     = '0;
                        done_pulse_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            data_q       <= '0;
            key_q        <= '0;
            res_q        <= '0;
            ed_q         <= 1'b0;
            cnt_q        <= '0;
            rd_idx_q     <= '0;
            error_q      <= 1'b0;
            done_pulse_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            key_q        <= key_d;
            res_q        <= res_d;
            ed_q         <= ed_d;
            cnt_q        <= cnt_d;
            rd_idx_q     <= rd_idx_d;
            error_q      <= error_d;
            done_pulse_q <= done_pulse_d;
            done_q       <= aes_done;
        end
    end

    assign wr_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign aes_start  = (state_q == S_START);
    assign rd_valid   = (state_q == S_UNLOAD);
    assign rd_data    = get_word(res_q, rd_idx_q);
    assign rd_idx     = rd_idx_q;
    assign aes_in     = data_q;
    assign aes_key    = key_q;
    assign aes_ed     = ed_q;
    assign done_pulse = done_pulse_q;
    assign error      = error_q;

endmodule

// File: tb/tb_aes_word_packer.sv
// Directed bench for aes_word_packer; the AES core is played by the test tasks with fixed vectors.
module tb_aes_word_packer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic         wr_sel = 1'b0;
    logic [2:0]   wr_idx = '0;
    logic [15:0]  wr_data = '0;
    logic         go = 1'b0;
    logic         encr_decr_in = 1'b0;
    logic [127:0] aes_in;
    logic [127:0] aes_key;
    logic         aes_ed;
    logic         aes_start;
    logic         aes_done = 1'b0;
    logic [127:0] aes_out = '0;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic [15:0]  rd_data;
    logic [2:0]   rd_idx;
    logic         busy;
    logic         done_pulse;
    logic         error;

    aes_word_packer #(.WORD_W(16), .NWORDS(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
        .go(go), .encr_decr_in(encr_decr_in),
        .aes_in(aes_in), .aes_key(aes_key), .aes_ed(aes_ed), .aes_start(aes_start),
        .aes_done(aes_done), .aes_out(aes_out),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_idx(rd_idx),
        .busy(busy), .done_pulse(done_pulse), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int n_start = 0;

    always @(posedge clk) if (aes_start === 1'b1) n_start <= n_start + 1;

    logic [127:0] KEY = 128'h5468_6174_7320_6D79_204B_756E_6720_4675;
    logic [127:0] PT  = 128'h5477_6F20_4F6E_6520_4E69_6E65_2054_776F;
    logic [127:0] CT  = 128'h29C3_505F_5714_20F6_4022_99B3_1A02_D73A;
    logic [15:0] ct_w [8] = '{16'h29C3, 16'h505F, 16'h5714, 16'h20F6,
                              16'h4022, 16'h99B3, 16'h1A02, 16'hD73A};
    logic [15:0] pt_w [8] = '{16'h5477, 16'h6F20, 16'h4F6E, 16'h6520,
                              16'h4E69, 16'h6E65, 16'h2054, 16'h776F};

    logic [15:0] got [8];
    int n_got, n_pulse, n_cyc;
    bit idx_seq_ok;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic sel, input int idx, input logic [15:0] d);
        wr_valid = 1'b1; wr_sel = sel; wr_idx = 3'(idx); wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic load_block(input logic sel, input logic [127:0] blk);
        for (int i = 0; i < 8; i++) write_word(sel, i, blk[127-16*i -: 16]);
    endtask

    task automatic pulse_go(input logic ed);
        go = 1'b1; encr_decr_in = ed;
        tick();
        go = 1'b0;
    endtask

    task automatic core_respond(input logic [127:0] r, input int delay, input bit hold);
        repeat (delay) tick();
        aes_out = r; aes_done = 1'b1;
        tick();
        if (!hold) aes_done = 1'b0;
    endtask

    // Drains the result stream with a repeating ready pattern; bounded by a cycle budget.
    task automatic drain(input logic [3:0] pat, input int plen);
        n_got = 0; n_pulse = 0; n_cyc = 0; idx_seq_ok = 1'b1;
        for (int c = 0; c < 200 && n_pulse == 0; c++) begin
            rd_ready = pat[c % plen];
            if (rd_valid && rd_ready) begin
                if (rd_idx !== 3'(n_got)) idx_seq_ok = 1'b0;
                if (n_got < 8) got[n_got] = rd_data;
                n_got++;
            end
            tick();
            n_cyc++;
            if (done_pulse) n_pulse++;
        end
        rd_ready = 1'b0;
        tick();
        if (done_pulse) n_pulse++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        n_checks++; if (aes_start !== 1'b0) begin n_fail++; $display("FAIL reset_aes_start got=%b exp=0", aes_start); end
        n_checks++; if ({aes_ed, done_pulse, error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {aes_ed, done_pulse, error}); end
        n_checks++; if (rd_idx !== 3'd0) begin n_fail++; $display("FAIL reset_rd_idx got=%0d exp=0", rd_idx); end
        n_checks++; if ({aes_in, aes_key} !== 256'd0) begin n_fail++; $display("FAIL reset_buffers got=%h_%h exp=0", aes_in, aes_key); end
    endtask

    task automatic test_encrypt();
        int s0;
        load_block(1'b1, KEY);
        load_block(1'b0, PT);
        n_checks++; if (aes_key !== KEY) begin n_fail++; $display("FAIL enc_key_buf got=%h exp=%h", aes_key, KEY); end
        n_checks++; if (aes_in !== PT) begin n_fail++; $display("FAIL enc_data_buf got=%h exp=%h", aes_in, PT); end
        s0 = n_start;
        pulse_go(1'b1);
        n_checks++; if (aes_start !== 1'b1) begin n_fail++; $display("FAIL enc_start got=%b exp=1", aes_start); end
        n_checks++; if ({busy, wr_ready, aes_ed} !== 3'b101) begin n_fail++; $display("FAIL enc_busy_ready_ed got=%b exp=101", {busy, wr_ready, aes_ed}); end
        core_respond(CT, 1, 1'b0);
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL enc_rd_valid got=%b exp=1", rd_valid); end
        drain(4'b1111, 1);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (got[k] !== ct_w[k]) begin n_fail++; $display("FAIL enc_word%0d got=%h exp=%h", k, got[k], ct_w[k]); end
        end
        n_checks++; if (n_got !== 8 || !idx_seq_ok) begin n_fail++; $display("FAIL enc_word_count got=%0d seq=%0d exp=8 seq=1", n_got, idx_seq_ok); end
        n_checks++; if (n_cyc !== 8) begin n_fail++; $display("FAIL enc_drain_cycles got=%0d exp=8", n_cyc); end
        n_checks++; if (n_pulse !== 1) begin n_fail++; $display("FAIL enc_done_pulse got=%0d exp=1", n_pulse); end
        n_checks++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL enc_start_count got=%0d exp=1", n_start - s0); end
    endtask

    task automatic test_decrypt();
        load_block(1'b0, CT);
        n_checks++; if (aes_key !== KEY) begin n_fail++; $display("FAIL dec_key_kept got=%h exp=%h", aes_key, KEY); end
        pulse_go(1'b0);
        n_checks++; if (aes_ed !== 1'b0 || aes_in !== CT) begin n_fail++; $display("FAIL dec_core_inputs ed=%b in=%h exp ed=0 in=%h", aes_ed, aes_in, CT); end
        core_respond(PT, 2, 1'b0);
        drain(4'b1111, 1);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (got[k] !== pt_w[k]) begin n_fail++; $display("FAIL dec_word%0d got=%h exp=%h", k, got[k], pt_w[k]); end
        end
        n_checks++; if (n_pulse !== 1) begin n_fail++; $display("FAIL dec_done_pulse got=%0d exp=1", n_pulse); end
    endtask

    task automatic test_stall();
        logic [2:0] prev_idx;
        logic [15:0] prev_data;
        bit prev_stall;
        int acc;
        bit seen_pulse;
        load_block(1'b0, PT);
        pulse_go(1'b1);
        core_respond(CT, 1, 1'b0);
        acc = 0; prev_stall = 1'b0; seen_pulse = 1'b0;
        prev_idx = '0; prev_data = '0;
        for (int c = 0; c < 100 && !seen_pulse; c++) begin
            rd_ready = (c % 3 == 0);
            if (prev_stall) begin
                n_checks++; if (rd_idx !== prev_idx || rd_data !== prev_data) begin n_fail++; $display("FAIL stall_hold got=%0d/%h exp=%0d/%h", rd_idx, rd_data, prev_idx, prev_data); end
            end
            if (rd_ready && rd_valid) begin
                n_checks++; if (rd_idx !== 3'(acc) || rd_data !== ct_w[acc]) begin n_fail++; $display("FAIL stall_word%0d got=%0d/%h exp=%0d/%h", acc, rd_idx, rd_data, acc, ct_w[acc]); end
                acc++;
            end
            prev_stall = rd_valid && !rd_ready;
            prev_idx = rd_idx; prev_data = rd_data;
            tick();
            if (done_pulse) seen_pulse = 1'b1;
        end
        rd_ready = 1'b0;
        n_checks++; if (acc !== 8 || !seen_pulse) begin n_fail++; $display("FAIL stall_complete got=%0d pulse=%0d exp=8 pulse=1", acc, seen_pulse); end
        tick();
    endtask

    task automatic test_timeout();
        bit any_rd;
        any_rd = 1'b0;
        pulse_go(1'b1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (rd_valid) any_rd = 1'b1;
            if (k == 15) begin
                n_checks++; if (error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early err=%b busy=%b exp err=0 busy=1", error, busy); end
            end
        end
        n_checks++; if (error !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_abort err=%b busy=%b rdy=%b exp 1/0/1", error, busy, wr_ready); end
        n_checks++; if (any_rd) begin n_fail++; $display("FAIL tmo_no_unload got=1 exp=0"); end
        tick();
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got=%b exp=1", error); end
        pulse_go(1'b1);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL tmo_go_clears got=%b exp=0", error); end
        core_respond(CT, 1, 1'b0);
        drain(4'b1111, 1);
        n_checks++; if (n_pulse !== 1 || got[0] !== 16'h29C3) begin n_fail++; $display("FAIL tmo_recover pulse=%0d w0=%h exp 1/29C3", n_pulse, got[0]); end
    endtask

    task automatic test_same_cycle();
        logic [127:0] exp_in;
        logic [15:0] low;
        int s0;
        exp_in = PT;
        exp_in[15:0] = 16'hBEEF;
        s0 = n_start;
        wr_valid = 1'b1; wr_sel = 1'b0; wr_idx = 3'd7; wr_data = 16'hBEEF;
        go = 1'b1; encr_decr_in = 1'b1;
        tick();
        wr_valid = 1'b0; go = 1'b0;
        low = aes_in[15:0];
        n_checks++; if (aes_start !== 1'b1 || low !== 16'hBEEF) begin n_fail++; $display("FAIL same_wr_go start=%b low=%h exp 1/BEEF", aes_start, low); end
        tick();
        go = 1'b1;
        wr_valid = 1'b1; wr_idx = 3'd0; wr_data = 16'h1234;
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL busy_wr_ready got=%b exp=0", wr_ready); end
        tick(); tick(); tick();
        go = 1'b0; wr_valid = 1'b0;
        n_checks++; if (aes_in !== exp_in) begin n_fail++; $display("FAIL busy_write_ignored got=%h exp=%h", aes_in, exp_in); end
        n_checks++; if (n_start - s0 !== 1 || busy !== 1'b1) begin n_fail++; $display("FAIL go_in_wait starts=%0d busy=%b exp 1/1", n_start - s0, busy); end
        core_respond(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1, 1'b1);
        drain(4'b1111, 1);
        n_checks++; if (got[0] !== 16'h0123 || got[7] !== 16'h3210 || n_pulse !== 1) begin n_fail++; $display("FAIL same_result w0=%h w7=%h pulse=%0d exp 0123/3210/1", got[0], got[7], n_pulse); end
        n_checks++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL same_start_total got=%0d exp=1", n_start - s0); end
    endtask

    task automatic test_stale_and_reset();
        int pulses;
        aes_out = {8{16'hDEAD}};
        pulse_go(1'b1);
        repeat (5) tick();
        n_checks++; if (rd_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stale_done rd_valid=%b busy=%b exp 0/1", rd_valid, busy); end
        aes_done = 1'b0;
        tick();
        core_respond(128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 1'b0);
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h1111) begin n_fail++; $display("FAIL fresh_done rd_valid=%b data=%h exp 1/1111", rd_valid, rd_data); end
        rd_ready = 1'b1;
        tick(); tick(); tick();
        rd_ready = 1'b0;
        n_checks++; if (rd_idx !== 3'd3 || rd_data !== 16'h4444) begin n_fail++; $display("FAIL unload_idx3 got=%0d/%h exp 3/4444", rd_idx, rd_data); end
        reset = 1'b1;
        tick();
        pulses = done_pulse ? 1 : 0;
        reset = 1'b0;
        n_checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_state rd_valid=%b busy=%b exp 0/0", rd_valid, busy); end
        n_checks++; if ({aes_in, aes_key} !== 256'd0 || rd_idx !== 3'd0) begin n_fail++; $display("FAIL midreset_buffers in=%h key=%h idx=%0d exp 0", aes_in, aes_key, rd_idx); end
        tick();
        if (done_pulse) pulses++;
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midreset_no_pulse got=%0d exp=0", pulses); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        test_reset();
        test_encrypt();
        test_decrypt();
        test_stall();
        test_timeout();
        test_same_cycle();
        test_stale_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
